// File: rtl/voter_pkg.sv
// rtl/voter_pkg.sv - shared state encoding and verdict codes for the voting session
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [2:0] V_APPROVE = 3'b100;
  localparam logic [2:0] V_TIE     = 3'b010;
  localparam logic [2:0] V_REJECT  = 3'b001;
  localparam logic [2:0] V_NONE    = 3'b000;

endpackage

// File: rtl/voter_popcount.sv
// rtl/voter_popcount.sv - combinational population count of an N-bit vector
module voter_popcount #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/voter_session.sv
// rtl/voter_session.sv - sequential voting session: collect first votes, close, decide, hold verdict
module voter_session
  import voter_pkg::*;
#(
  parameter int N_VOTERS    = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = $clog2(N_VOTERS + 1),
  parameter int TMR_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close_req,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic                dup_err,
  output logic                done,
  output logic [3:1]          O,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic [CNT_W-1:0]    no_cnt
);

  // Doubling yes needs one extra bit, so the voter count is widened to match.
  localparam logic [CNT_W:0] N_EXT = (CNT_W + 1)'(N_VOTERS);

  state_t              state;
  logic [N_VOTERS-1:0] yes_acc;
  logic [TMR_W-1:0]    timer;
  logic [CNT_W-1:0]    yes_pop;
  logic [CNT_W:0]      yes_x2;
  logic [N_VOTERS-1:0] new_votes;
  logic [N_VOTERS-1:0] mask_next;
  logic                dup_hit;
  logic                close_now;

  voter_popcount #(.N(N_VOTERS), .W(CNT_W)) u_yes_pop (
    .bits  (yes_acc),
    .count (yes_pop)
  );

  always_comb begin
    new_votes = vote_valid & ~voted_mask;
    mask_next = voted_mask | new_votes;
    dup_hit   = |(vote_valid & voted_mask);
    close_now = (mask_next == '1) || (timer == TMR_W'(TIMEOUT_CYC - 1)) || close_req;
    yes_x2    = {yes_pop, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      voted_mask <= '0;
      yes_acc    <= '0;
      timer      <= '0;
      O          <= V_NONE;
      yes_cnt    <= '0;
      no_cnt     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dup_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      dup_err <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (start) begin
            state      <= COLLECT;
            busy       <= 1'b1;
            voted_mask <= '0;
            yes_acc    <= '0;
            timer      <= '0;
            O          <= V_NONE;
            yes_cnt    <= '0;
            no_cnt     <= '0;
          end
        end
        COLLECT: begin
          voted_mask <= mask_next;
          yes_acc    <= yes_acc | (new_votes & vote_yes);
          timer      <= timer + 1'b1;
          dup_err    <= dup_hit;
          if (close_now) state <= DECIDE;
        end
        DECIDE: begin
          state   <= HOLD;
          busy    <= 1'b0;
          done    <= 1'b1;
          yes_cnt <= yes_pop;
          no_cnt  <= CNT_W'(N_VOTERS) - yes_pop;
          if (yes_x2 > N_EXT)       O <= V_APPROVE;
          else if (yes_x2 == N_EXT) O <= V_TIE;
          else                      O <= V_REJECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/voter_session.md
Name: voter_session

Overview:
- Parametrised, sequential successor to the team's 4-input combinational voter.
- Runs a voting session across N_VOTERS independent voter inputs: opens on start, latches each voter's first vote, then closes when every voter has voted, on a timeout, or on a forced close.
- Produces a registered one-hot verdict (approve / tie / reject) plus yes/no counts, for use by the ballot controller and display logic.

Parameters:
- N_VOTERS, 4, number of voter channels (2..32).
- TIMEOUT_CYC, 16, maximum COLLECT cycles before forced close (>=1).
- CNT_W, $clog2(N_VOTERS+1), width of the vote counters (derived; do not override).
- TMR_W, $clog2(TIMEOUT_CYC+1), width of the timeout counter (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  opens a session when in IDLE or HOLD.
- close_req  in  1  forces the session to close early when in COLLECT.
- vote_valid  in  N_VOTERS  per-voter vote strobe.
- vote_yes  in  N_VOTERS  per-voter value, 1=yes, 0=no; sampled only with vote_valid.
- busy  out  1  high in COLLECT and DECIDE.
- voted_mask  out  N_VOTERS  voters whose vote has been latched this session.
- dup_err  out  1  one-cycle pulse when an already-voted channel strobes again.
- done  out  1  one-cycle pulse on the first HOLD cycle.
- O  out  3 [3:1]  one-hot verdict: 3'b100 approve, 3'b010 tie, 3'b001 reject, 3'b000 none.
- yes_cnt  out  CNT_W  latched yes count.
- no_cnt  out  CNT_W  latched no count. Abstentions count as no.

Behaviour:
- Reset: state=IDLE. All outputs 0: O=3'b000, voted_mask=0, counts=0, busy/done/dup_err=0. Reset mid-session discards the session with no verdict.
- FSM has four states: IDLE, COLLECT, DECIDE, HOLD.
- IDLE -> COLLECT on start. On that edge: voted_mask, yes-accumulator and timer clear; O and counts clear to 0.
- COLLECT: for each channel i with vote_valid[i]=1 and voted_mask[i]=0, set voted_mask[i] and record vote_yes[i]. Multiple channels may vote in the same cycle; all are taken.
- Duplicate vote: a channel strobing with voted_mask[i]=1 is ignored and dup_err pulses the next cycle. The same applies to a strobe in the same cycle as close.
- Timer: increments every COLLECT cycle.
- COLLECT -> DECIDE at the end of the cycle in which any of these holds:
  - the mask including this cycle's votes is all-ones;
  - timer == TIMEOUT_CYC-1;
  - close_req=1.
  Votes arriving in the closing cycle are counted.
- DECIDE (1 cycle): compute yes=popcount, no=N_VOTERS-yes.
  - 2*yes > N_VOTERS gives approve.
  - 2*yes == N_VOTERS gives tie.
  - Otherwise reject.
  - Odd N_VOTERS can never tie.
  - The result registers at the end of DECIDE.
- HOLD: O, yes_cnt, no_cnt and voted_mask stay stable. done=1 only in the first HOLD cycle. HOLD -> COLLECT on start, with clear as above.
- start is ignored in COLLECT and DECIDE. close_req is ignored outside COLLECT. vote_valid is ignored outside COLLECT.
- Latency: last vote sampled in cycle t; DECIDE in t+1; HOLD with done=1 and valid O in t+2.
- Width rules: popcount is CNT_W bits. The comparison uses CNT_W+1 bits so that 2*yes does not overflow.

Decomposition:
- Shared package voter_pkg holds:
  - state enum (IDLE, COLLECT, DECIDE, HOLD);
  - verdict constants V_APPROVE=3'b100, V_TIE=3'b010, V_REJECT=3'b001, V_NONE=3'b000.
- One sub-module, voter_popcount: parametrised combinational popcount of N_VOTERS bits to CNT_W bits. It is reused by the top for yes counting.

Test Plan:
- Defaults; start, then votes 1,1,1,0 all in one cycle -> DECIDE next cycle, then done=1, O=3'b100, yes_cnt=3, no_cnt=1.
- Defaults; votes 1,0,1,0 spread over 4 cycles -> O=3'b010, yes=2, no=2, done exactly one cycle.
- Defaults; only voter0 votes yes, no close -> close after 16 COLLECT cycles, O=3'b001, yes=1, no=3, voted_mask=4'b0001.
- Voter2 votes yes, then votes no 2 cycles later -> dup_err pulses once, the second vote is ignored, and voter2 counts as yes.
- N_VOTERS=5; 3 yes, then close_req -> O=3'b100. Separately, 2 yes then close -> O=3'b001, never tie.
- rst asserted in COLLECT after 2 votes -> next cycle IDLE, O=3'b000, mask=0. A new session then behaves normally. start during COLLECT has no effect.
